// File: rtl/grid_accum_pkg.sv
// grid_accum_pkg: shared definitions for the gridding back end.
//   state_t     - controller states (CLEAR, ACCUM, DRAIN, DUMP)
//   PIPE_DEPTH  - depth of the accumulate pipeline (S1..S3)
//   cplx_t      - complex word, signed real and imaginary parts
//   sat_add     - signed add clamped to a w-bit two's-complement range
package grid_accum_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    localparam int PIPE_DEPTH = 3;

    localparam int CPLX_W = 32;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Operands arrive sign-extended to 64 bits; the caller keeps the low w bits.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi)
            return hi[63:0];
        else if (s < lo)
            return lo[63:0];
        return s[63:0];
    endfunction

endpackage

// File: rtl/grid_accum_cmul.sv
// cmul_pipe: registered complex multiply, 1-cycle latency.
//   p = x * c at full width, arithmetic right shift by COEF_FRAC,
//   truncated to PRECISION bits per part.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid                 operand valid
//   in_xr, in_xi             sample real / imag (signed)
//   in_cr, in_ci             coefficient real / imag (signed)
//   out_valid                product valid (in_valid delayed by one)
//   out_pr, out_pi           product real / imag (signed)
module cmul_pipe #(
    parameter int PRECISION = 32,
    parameter int COEF_FRAC = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [PRECISION-1:0] in_xr,
    input  logic [PRECISION-1:0] in_xi,
    input  logic [PRECISION-1:0] in_cr,
    input  logic [PRECISION-1:0] in_ci,
    output logic                 out_valid,
    output logic [PRECISION-1:0] out_pr,
    output logic [PRECISION-1:0] out_pi
);

    localparam int PW = 2 * PRECISION;
    localparam int FW = PW + 1;

    logic signed [PW-1:0] rr, ii, ri, ir;
    logic signed [FW-1:0] full_r, full_i;

    // One extra bit so (-2^(P-1))^2 + (-2^(P-1))^2 cannot overflow.
    always_comb begin
        rr     = $signed(in_xr) * $signed(in_cr);
        ii     = $signed(in_xi) * $signed(in_ci);
        ri     = $signed(in_xr) * $signed(in_ci);
        ir     = $signed(in_xi) * $signed(in_cr);
        full_r = FW'(rr) - FW'(ii);
        full_i = FW'(ri) + FW'(ir);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pr    <= '0;
            out_pi    <= '0;
        end else begin
            out_valid <= in_valid;
            out_pr    <= PRECISION'(full_r >>> COEF_FRAC);
            out_pi    <= PRECISION'(full_i >>> COEF_FRAC);
        end
    end

endmodule

// File: rtl/grid_accum.sv
// grid_accum: gridding back end. Multiplies each sample by the coefficient at
// cind and accumulates into the complex grid at gind; a dump sweep streams the
// grid out and clears it.
// Build option: define GRID_SATURATE_EN for a saturating grid add (default wraps).
// Ports:
//   clk, rst                      clock, async active-high reset
//   valid, gind, cind             input word strobe, grid / coefficient address
//   indatar, indatai              sample real / imag
//   coef_we, coef_addr            coefficient table write strobe / address
//   coef_datar, coef_datai        coefficient write data
//   dump                          request grid readout
//   busy                          high outside ACCUM
//   out_valid, out_addr           readout strobe / grid address
//   out_datar, out_datai          readout data
//   err_drop                      sticky: input word discarded
//
// state    | meaning
// ---------+----------------------------------------------------
// CLEAR    | zero every grid word, entered after reset
// ACCUM    | accept input words
// DRAIN    | let in-flight words commit before the sweep
// DUMP     | read, present and zero every grid word in order
module grid_accum
    import grid_accum_pkg::*;
#(
    parameter int PRECISION = 32,
    parameter int GSIZE     = 32,
    parameter int CDEPTH    = 2048,
    parameter int COEF_FRAC = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [15:0]          gind,
    input  logic [15:0]          cind,
    input  logic [PRECISION-1:0] indatar,
    input  logic [PRECISION-1:0] indatai,
    input  logic                 coef_we,
    input  logic [15:0]          coef_addr,
    input  logic [PRECISION-1:0] coef_datar,
    input  logic [PRECISION-1:0] coef_datai,
    input  logic                 dump,
    output logic                 busy,
    output logic                 out_valid,
    output logic [15:0]          out_addr,
    output logic [PRECISION-1:0] out_datar,
    output logic [PRECISION-1:0] out_datai,
    output logic                 err_drop
);

    localparam int GDEPTH = GSIZE * GSIZE;
    localparam int GAW    = $clog2(GDEPTH);
    localparam int CAW    = $clog2(CDEPTH);
    localparam int WW     = 2 * PRECISION;
    localparam logic [GAW-1:0] SWEEP_END = GAW'(GDEPTH - 1);

    // Address bits above the memory depths are ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{gind, cind, coef_addr};

    state_t         state_q, state_d;
    logic [GAW-1:0] sweep_addr;
    logic           sweep_act, sweep_last;
    logic [1:0]     drain_cnt;
    logic           accept;

    assign sweep_last = (sweep_addr == SWEEP_END);
    assign accept     = valid && (state_q == ST_ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_CLEAR;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sweep_act = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_CLEAR: begin
                sweep_act = 1'b1;
                if (sweep_last)
                    state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                busy = 1'b0;
                if (dump)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'd0)
                    state_d = ST_DUMP;
            end
            ST_DUMP: begin
                sweep_act = 1'b1;
                if (sweep_last)
                    state_d = ST_ACCUM;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sweep_addr <= '0;
        else if (sweep_act)
            sweep_addr <= sweep_last ? '0 : sweep_addr + 1'b1;
    end

    // Loaded while in ACCUM so DRAIN lasts exactly PIPE_DEPTH cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drain_cnt <= 2'(PIPE_DEPTH - 1);
        else if (state_q == ST_ACCUM)
            drain_cnt <= 2'(PIPE_DEPTH - 1);
        else if (state_q == ST_DRAIN && drain_cnt != 2'd0)
            drain_cnt <= drain_cnt - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_drop <= 1'b0;
        else if (valid && state_q != ST_ACCUM)
            err_drop <= 1'b1;
    end

    // Coefficient table: read-old on a same-address write.
    logic [WW-1:0] coef_mem [CDEPTH];
    logic [WW-1:0] coef_q;

    always_ff @(posedge clk) begin
        if (coef_we)
            coef_mem[coef_addr[CAW-1:0]] <= {coef_datar, coef_datai};
        coef_q <= coef_mem[cind[CAW-1:0]];
    end

    // S1
    logic                 s1_valid;
    logic [GAW-1:0]       s1_gind;
    logic [PRECISION-1:0] s1_xr, s1_xi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_gind  <= '0;
            s1_xr    <= '0;
            s1_xi    <= '0;
        end else begin
            s1_valid <= accept;
            s1_gind  <= gind[GAW-1:0];
            s1_xr    <= indatar;
            s1_xi    <= indatai;
        end
    end

    // S2
    logic                 s2_valid;
    logic [GAW-1:0]       s2_gind;
    logic [PRECISION-1:0] prod_r, prod_i;

    cmul_pipe #(
        .PRECISION (PRECISION),
        .COEF_FRAC (COEF_FRAC)
    ) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_xr     (s1_xr),
        .in_xi     (s1_xi),
        .in_cr     (coef_q[WW-1:PRECISION]),
        .in_ci     (coef_q[PRECISION-1:0]),
        .out_valid (s2_valid),
        .out_pr    (prod_r),
        .out_pi    (prod_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2_gind <= '0;
        else
            s2_gind <= s1_gind;
    end

    // Grid memory, shared by the accumulate path and the CLEAR/DUMP sweep.
    logic [WW-1:0]  grid_mem [GDEPTH];
    logic [WW-1:0]  grid_q;
    logic [GAW-1:0] grid_raddr, grid_waddr;
    logic [WW-1:0]  grid_wdata;
    logic           grid_we;

    logic                 s3_valid, wb_valid;
    logic [GAW-1:0]       s3_gind, wb_gind;
    logic [PRECISION-1:0] s3_r, s3_i, wb_r, wb_i;

    assign grid_raddr = (state_q == ST_DUMP) ? sweep_addr : s1_gind;
    assign grid_we    = sweep_act || s3_valid;
    assign grid_waddr = sweep_act ? sweep_addr : s3_gind;
    assign grid_wdata = sweep_act ? '0 : {s3_r, s3_i};

    always_ff @(posedge clk) begin
        if (grid_we)
            grid_mem[grid_waddr] <= grid_wdata;
        grid_q <= grid_mem[grid_raddr];
    end

    // The grid read for the S2 word misses the S3 word (not yet written) and
    // the word written on the same edge as the read (read-old). Both are
    // forwarded, youngest first.
    logic [PRECISION-1:0] base_r, base_i, sum_r, sum_i;

    always_comb begin
        base_r = grid_q[WW-1:PRECISION];
        base_i = grid_q[PRECISION-1:0];
        if (s3_valid && s3_gind == s2_gind) begin
            base_r = s3_r;
            base_i = s3_i;
        end else if (wb_valid && wb_gind == s2_gind) begin
            base_r = wb_r;
            base_i = wb_i;
        end
`ifdef GRID_SATURATE_EN
        sum_r = PRECISION'(sat_add(64'($signed(base_r)), 64'($signed(prod_r)), PRECISION));
        sum_i = PRECISION'(sat_add(64'($signed(base_i)), 64'($signed(prod_i)), PRECISION));
`else
        sum_r = base_r + prod_r;
        sum_i = base_i + prod_i;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_gind  <= '0;
            s3_r     <= '0;
            s3_i     <= '0;
            wb_valid <= 1'b0;
            wb_gind  <= '0;
            wb_r     <= '0;
            wb_i     <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_gind  <= s2_gind;
            s3_r     <= sum_r;
            s3_i     <= sum_i;
            wb_valid <= s3_valid;
            wb_gind  <= s3_gind;
            wb_r     <= s3_r;
            wb_i     <= s3_i;
        end
    end

    // Readout: the sweep read issued in DUMP returns one cycle later and is
    // registered onto the outputs, so the first word trails DUMP entry by two.
    logic           rd_v;
    logic [GAW-1:0] rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v      <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_datar <= '0;
            out_datai <= '0;
        end else begin
            rd_v      <= (state_q == ST_DUMP);
            rd_addr   <= sweep_addr;
            out_valid <= rd_v;
            if (rd_v) begin
                out_addr  <= 16'(rd_addr);
                out_datar <= grid_q[WW-1:PRECISION];
                out_datai <= grid_q[PRECISION-1:0];
            end
        end
    end

endmodule

// File: tb/tb_grid_accum.sv
module tb_grid_accum;

    localparam int N  = 1024;
    localparam int CD = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] gind = '0;
    logic [15:0] cind = '0;
    logic [31:0] indatar = '0;
    logic [31:0] indatai = '0;
    logic        coef_we = 1'b0;
    logic [15:0] coef_addr = '0;
    logic [31:0] coef_datar = '0;
    logic [31:0] coef_datai = '0;
    logic        dump = 1'b0;
    logic        busy;
    logic        out_valid;
    logic [15:0] out_addr;
    logic [31:0] out_datar;
    logic [31:0] out_datai;
    logic        err_drop;

    int total = 0;
    int bad   = 0;

    logic signed [31:0] m_gr [N];
    logic signed [31:0] m_gi [N];
    logic signed [31:0] m_cr [CD];
    logic signed [31:0] m_ci [CD];
    logic [31:0]        d_r  [N];
    logic [31:0]        d_i  [N];

    grid_accum dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .gind       (gind),
        .cind       (cind),
        .indatar    (indatar),
        .indatai    (indatai),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_datar (coef_datar),
        .coef_datai (coef_datai),
        .dump       (dump),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_datar  (out_datar),
        .out_datai  (out_datai),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] acc(input logic signed [31:0] a, input logic signed [31:0] b);
`ifdef GRID_SATURATE_EN
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 64'sd2147483647)
            return 32'sh7fffffff;
        if (s < -64'sd2147483648)
            return 32'sh80000000;
        return 32'(s);
`else
        return a + b;
`endif
    endfunction

    task automatic model_acc(input logic [15:0] g, input logic [15:0] c,
                             input logic signed [31:0] xr, input logic signed [31:0] xi);
        int ga, ca;
        logic signed [64:0] ar, ai, br, bi, pr, pi;
        ga = int'(g) % N;
        ca = int'(c) % CD;
        ar = xr;
        ai = xi;
        br = m_cr[ca];
        bi = m_ci[ca];
        pr = ar * br - ai * bi;
        pi = ar * bi + ai * br;
        m_gr[ga] = acc(m_gr[ga], 32'(pr >>> 30));
        m_gi[ga] = acc(m_gi[ga], 32'(pi >>> 30));
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            m_gr[k] = '0;
            m_gi[k] = '0;
        end
    endtask

    task automatic wr_coef(input logic [15:0] a, input logic [31:0] r, input logic [31:0] i);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_datar = r;
        coef_datai = i;
        @(negedge clk);
        coef_we = 1'b0;
        m_cr[int'(a) % CD] = r;
        m_ci[int'(a) % CD] = i;
    endtask

    task automatic send(input logic [15:0] g, input logic [15:0] c,
                        input logic signed [31:0] xr, input logic signed [31:0] xi,
                        input bit apply);
        valid   = 1'b1;
        gind    = g;
        cind    = c;
        indatar = xr;
        indatai = xi;
        if (apply)
            model_acc(g, c, xr, xi);
        @(negedge clk);
    endtask

    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        chk(tag, cnt, 1024);
    endtask

    task automatic start_dump();
        valid = 1'b0;
        chk("busy_before_dump", busy, 0);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic collect_dump(input int exp_lat, input bit held);
        int lat, bl;
        lat = 0;
        bl  = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        chk("dump_latency", lat, exp_lat);
        for (int i = 0; i < N; i++) begin
            if (i > 0)
                @(negedge clk);
            if (!busy)
                bl++;
            chk($sformatf("dump[%0d]", i), {out_valid, out_addr, out_datar, out_datai},
                {1'b1, 16'(i), m_gr[i], m_gi[i]});
            d_r[i] = out_datar;
            d_i[i] = out_datai;
        end
        chk("busy_at_last_word", busy, held ? 1 : 0);
        chk("busy_low_cycles", bl, held ? 1 : 2);
        @(negedge clk);
        chk("out_valid_end", out_valid, 0);
        clear_model();
    endtask

    task automatic rand_round();
        logic [15:0] ca [8];
        logic [15:0] g, c;
        valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ca[k] = 16'($urandom_range(0, CD - 1));
            wr_coef(ca[k], $urandom, $urandom);
        end
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                @(negedge clk);
            end
            if ($urandom_range(0, 1) == 1)
                g = 16'(($urandom_range(0, 63) << 10) | $urandom_range(0, 3));
            else
                g = 16'($urandom);
            c = ca[$urandom_range(0, 7)] + 16'(CD * $urandom_range(0, 31));
            send(g, c, $urandom, $urandom, 1'b1);
        end
        valid = 1'b0;
    endtask

    initial begin
        clear_model();
        for (int k = 0; k < CD; k++) begin
            m_cr[k] = '0;
            m_ci[k] = '0;
        end

        // reset state and CLEAR
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", {out_datar, out_datai}, 0);
        chk("rst_err_drop", err_drop, 0);
        rst = 1'b0;
        wait_clear("clear_cycles");
        start_dump();
        collect_dump(5, 1'b0);

        // unit coefficient
        wr_coef(16'd5, 32'h4000_0000, 32'd0);
        wr_coef(16'd1, 32'd0, 32'h4000_0000);
        send(16'd33, 16'd5, 32'sd100, -32'sd7, 1'b1);
        start_dump();
        collect_dump(5, 1'b0);
        chk("unit_coef_33", {d_r[33], d_i[33]}, {32'd100, -32'sd7});
        chk("unit_coef_32", {d_r[32], d_i[32]}, 64'd0);

        // back-to-back identical gind with coefficient j
        repeat (4) send(16'd10, 16'd1, 32'sd100, -32'sd7, 1'b1);
        start_dump();
        collect_dump(5, 1'b0);
        chk("fwd_same_10", {d_r[10], d_i[10]}, {32'd28, 32'd400});

        // alternating gind
        send(16'd2, 16'd5, 32'sd1, 32'sd0, 1'b1);
        send(16'd3, 16'd5, 32'sd1, 32'sd0, 1'b1);
        send(16'd2, 16'd5, 32'sd1, 32'sd0, 1'b1);
        send(16'd3, 16'd5, 32'sd1, 32'sd0, 1'b1);
        send(16'd2, 16'd5, 32'sd1, 32'sd0, 1'b1);
        start_dump();
        collect_dump(5, 1'b0);
        chk("alt_2", {d_r[2], d_i[2]}, {32'd3, 32'd0});
        chk("alt_3", {d_r[3], d_i[3]}, {32'd2, 32'd0});

        // overflow behaviour
        send(16'd50, 16'd5, 32'sh7fffffff, 32'sd0, 1'b1);
        send(16'd50, 16'd5, 32'sh7fffffff, 32'sd0, 1'b1);
        start_dump();
        collect_dump(5, 1'b0);
`ifdef GRID_SATURATE_EN
        chk("ovf_50", {d_r[50], d_i[50]}, {32'h7fffffff, 32'd0});
`else
        chk("ovf_50", {d_r[50], d_i[50]}, {32'hfffffffe, 32'd0});
`endif

        // same-cycle coefficient write/read, address wrap
        coef_we    = 1'b1;
        coef_addr  = 16'd5;
        coef_datar = 32'd0;
        coef_datai = 32'h4000_0000;
        send(16'd60, 16'd5, 32'sd7, 32'sd3, 1'b1);
        coef_we = 1'b0;
        m_cr[5] = 32'd0;
        m_ci[5] = 32'h4000_0000;
        send(16'd61, 16'd5, 32'sd7, 32'sd3, 1'b1);
        valid = 1'b0;
        wr_coef(16'd5, 32'h4000_0000, 32'd0);
        send(16'h0400 | 16'd70, 16'd5 + 16'd2048, 32'sd9, -32'sd9, 1'b1);
        start_dump();
        collect_dump(5, 1'b0);
        chk("coef_old_60", {d_r[60], d_i[60]}, {32'd7, 32'd3});
        chk("coef_new_61", {d_r[61], d_i[61]}, {-32'sd3, 32'sd7});
        chk("wrap_70", {d_r[70], d_i[70]}, {32'd9, -32'sd9});

        // randomized rounds
        for (int r = 0; r < 2; r++) begin
            rand_round();
            start_dump();
            collect_dump(5, 1'b0);
        end

        // dump held across completion
        rand_round();
        chk("busy_before_held", busy, 0);
        dump = 1'b1;
        collect_dump(6, 1'b1);
        dump = 1'b0;
        collect_dump(4, 1'b0);

        // input dropped while busy
        wr_coef(16'd5, 32'h4000_0000, 32'd0);
        start_dump();
        send(16'd77, 16'd5, 32'sd1000, 32'sd0, 1'b0);
        valid = 1'b0;
        collect_dump(4, 1'b0);
        chk("err_drop_set", err_drop, 1);
        start_dump();
        collect_dump(5, 1'b0);
        chk("drop_absent_77", {d_r[77], d_i[77]}, 64'd0);
        chk("err_drop_sticky", err_drop, 1);

        // reset mid-operation
        send(16'd200, 16'd5, 32'sd5, 32'sd5, 1'b1);
        send(16'd201, 16'd5, 32'sd6, 32'sd6, 1'b1);
        send(16'd200, 16'd5, 32'sd7, 32'sd7, 1'b1);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_err_drop", err_drop, 0);
        chk("rst2_busy", busy, 1);
        chk("rst2_out_valid", out_valid, 0);
        rst = 1'b0;
        clear_model();
        wait_clear("clear2_cycles");
        start_dump();
        collect_dump(5, 1'b0);
        chk("rst2_200", {d_r[200], d_i[200]}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
